// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Single-outstanding load/store unit between a core-side request port and a
// word-organised data memory. Each request is checked for size, alignment
// and legality. A legal request spends one ACCESS cycle driving the memory,
// then one RESP cycle returning the result. An illegal request goes straight
// to RESP with resp_fault set and never touches the memory.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   req_valid / req_ready    request handshake; accepted on a rising edge
//   req_we                   1 = store, 0 = load
//   req_funct3               000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr, req_wdata      byte address and right-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_fault   extended load data and fault flag
//   mem_addy                 word index driven to the memory (ACCESS only)
//   mem_datain               lane-replicated store data (ACCESS only)
//   mem_wen, mem_ren         write and read strobes (ACCESS only)
//   mem_byte_selector        byte-lane enables, bit n covers bits [8n+7:8n]
//   mem_dataout              read word; the memory updates it on falling clk
// ---------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addy,
  output logic [31:0] mem_datain,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [3:0]  mem_byte_selector,
  input  logic [31:0] mem_dataout
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e      state_q, state_d;

  // Request fields still needed when the load data returns.
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;

  logic [31:0] mem_addy_q, mem_addy_d;
  logic [31:0] mem_datain_q, mem_datain_d;
  logic        mem_wen_q, mem_wen_d;
  logic        mem_ren_q, mem_ren_d;
  logic [3:0]  mem_sel_q, mem_sel_d;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;

  logic        req_fault;
  logic [3:0]  req_sel;
  logic [31:0] req_datain;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // -------------------------------------------------------------------------
  // Request decode: legality, lane enables and lane-replicated store data.
  // -------------------------------------------------------------------------
  always_comb begin
    req_fault = 1'b0;
    unique case (req_funct3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = req_addr[0];
      3'b010:  req_fault = |req_addr[1:0];
      3'b100:  req_fault = req_we;
      3'b101:  req_fault = req_we | req_addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  always_comb begin
    req_sel    = 4'b0000;
    req_datain = 32'h0;
    // funct3[1:0] carries the access size once illegal codes are excluded.
    unique case (req_funct3[1:0])
      2'b00: begin
        req_sel    = 4'b0001 << req_addr[1:0];
        req_datain = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_sel    = 4'b0011 << req_addr[1:0];
        req_datain = {2{req_wdata[15:0]}};
      end
      default: begin
        req_sel    = 4'b1111;
        req_datain = req_wdata;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load data extraction from the word returned by the memory.
  // -------------------------------------------------------------------------
  always_comb begin
    ld_byte = 8'h0;
    unique case (addr_lo_q)
      2'd0: ld_byte = mem_dataout[7:0];
      2'd1: ld_byte = mem_dataout[15:8];
      2'd2: ld_byte = mem_dataout[23:16];
      2'd3: ld_byte = mem_dataout[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_dataout[31:16] : mem_dataout[15:0];

    ld_data = mem_dataout;
    unique case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_dataout;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Memory and response registers default to zero so they
  // are only non-zero in the single state that owns them.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    mem_addy_d   = 32'h0;
    mem_datain_d = 32'h0;
    mem_wen_d    = 1'b0;
    mem_ren_d    = 1'b0;
    mem_sel_d    = 4'b0000;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_fault_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          if (req_fault) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d      = StAccess;
            mem_addy_d   = {2'b00, req_addr[31:2]};
            mem_wen_d    = req_we;
            mem_ren_d    = ~req_we;
            mem_sel_d    = req_sel;
            mem_datain_d = req_we ? req_datain : 32'h0;
          end
        end
      end
      StAccess: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        // mem_ren_q distinguishes a load from a store in this cycle.
        if (mem_ren_q) begin
          resp_rdata_d = ld_data;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      mem_addy_q   <= 32'h0;
      mem_datain_q <= 32'h0;
      mem_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_sel_q    <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      mem_addy_q   <= mem_addy_d;
      mem_datain_q <= mem_datain_d;
      mem_wen_q    <= mem_wen_d;
      mem_ren_q    <= mem_ren_d;
      mem_sel_q    <= mem_sel_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Ready is gated by rst directly so it drops the instant reset asserts.
  assign req_ready         = (state_q == StIdle) && !rst;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = resp_rdata_q;
  assign resp_fault        = resp_fault_q;
  assign mem_addy          = mem_addy_q;
  assign mem_datain        = mem_datain_q;
  assign mem_wen           = mem_wen_q;
  assign mem_ren           = mem_ren_q;
  assign mem_byte_selector = mem_sel_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Bench for load_store_unit: a 64-word memory that updates on the falling
// edge, directed scenarios with fixed expected values, then random requests
// checked against a byte-array reference of the memory contents.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addy;
  logic [31:0] mem_datain;
  logic        mem_wen;
  logic        mem_ren;
  logic [3:0]  mem_byte_selector;
  logic [31:0] mem_dataout;

  int total = 0;
  int bad   = 0;

  load_store_unit dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_addy         (mem_addy),
    .mem_datain       (mem_datain),
    .mem_wen          (mem_wen),
    .mem_ren          (mem_ren),
    .mem_byte_selector(mem_byte_selector),
    .mem_dataout      (mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: 64 words, out-of-range reads return 0, writes ignored.
  logic [31:0] mem_words [0:63];
  logic        mem_clear;

  always @(negedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem_words[i] <= 32'h0;
      mem_dataout <= 32'h0;
    end else begin
      if (mem_wen && mem_addy < 32'd64) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byte_selector[b]) mem_words[mem_addy[5:0]][8*b +: 8] <= mem_datain[8*b +: 8];
        end
      end
      mem_dataout <= (mem_ren && mem_addy < 32'd64) ? mem_words[mem_addy[5:0]] : 32'h0;
    end
  end

  // Reference: byte-addressed contents of the 256 in-range bytes.
  logic [7:0] ref_mem [0:255];

  function automatic int f3_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic model_fault(input logic we, input logic [2:0] f3,
                                       input logic [31:0] a);
    int sz;
    sz = f3_size(f3);
    if (sz == 0) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    v  = 32'h0;
    sz = f3_size(f3);
    if (a < 32'd256) begin
      for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[8'(a + 32'(k))]) << (8 * k));
    end
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    if (a < 32'd256) begin
      for (int k = 0; k < f3_size(f3); k++) ref_mem[8'(a + 32'(k))] = d[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE (entered at #1 after a rising edge) and check
  // every cycle through the response. Returns the observed resp_rdata.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got);
    logic        flt;
    logic [31:0] exp_rd;
    int          sz;
    int          guard;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_req", 32'(req_ready), 32'd1);
    flt    = model_fault(we, f3, a);
    sz     = f3_size(f3);
    exp_rd = (we || flt) ? 32'h0 : model_load(f3, a);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got       = 32'h0;
    if (flt) begin
      check("flt_valid", 32'(resp_valid), 32'd1);
      check("flt_fault", 32'(resp_fault), 32'd1);
      check("flt_rdata", resp_rdata, 32'h0);
      check("flt_strobes", {mem_wen, mem_ren, mem_byte_selector}, 32'h0);
      check("flt_addy", mem_addy, 32'h0);
      got = resp_rdata;
    end else begin
      check("acc_ready", 32'(req_ready), 32'd0);
      check("acc_valid", 32'(resp_valid), 32'd0);
      check("acc_addy", mem_addy, a >> 2);
      check("acc_wen", 32'(mem_wen), 32'(we));
      check("acc_ren", 32'(mem_ren), 32'(!we));
      check("acc_sel", 32'(mem_byte_selector),
            sz == 4 ? 32'hF : (((32'd1 << sz) - 32'd1) << a[1:0]));
      check("acc_datain", mem_datain,
            !we ? 32'h0 : sz == 1 ? wd[7:0] * 32'h0101_0101 :
            sz == 2 ? wd[15:0] * 32'h0001_0001 : wd);
      @(posedge clk); #1;
      check("rsp_valid", 32'(resp_valid), 32'd1);
      check("rsp_fault", 32'(resp_fault), 32'd0);
      check("rsp_rdata", resp_rdata, exp_rd);
      check("rsp_strobes", {mem_wen, mem_ren, mem_byte_selector}, 32'h0);
      got = resp_rdata;
      if (we) model_store(f3, a, wd);
    end
    @(posedge clk); #1;
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  int          n_acc;
  int          n_rsp;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
    rst        = 1'b1;
    mem_clear  = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_valid  = 1'b1;  // must be ignored during reset
    repeat (2) @(posedge clk);
    #1;
    mem_clear = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_fault", 32'(resp_fault), 32'd0);
    check("rst_strobes", {mem_wen, mem_ren, mem_byte_selector}, 32'h0);
    check("rst_addy", mem_addy, 32'h0);
    check("rst_datain", mem_datain, 32'h0);
    req_valid = 1'b0;
    rst       = 1'b0;
    #1;
    check("rel_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Directed scenarios.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd);
    check("dir_sw_rdata", rd, 32'h0);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd);
    check("dir_lb", rd, 32'hFFFF_FFDE);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, rd);
    check("dir_lbu", rd, 32'h0000_00DE);
    do_req(1'b1, 3'b001, 32'h12, 32'h0000_1234, rd);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, rd);
    check("dir_lhu", rd, 32'h0000_1234);
    check("dir_word4", mem_words[4], 32'h1234_BEEF);
    do_req(1'b0, 3'b010, 32'h11, 32'h0, rd);
    do_req(1'b1, 3'b101, 32'h10, 32'h5555_5555, rd);
    check("dir_word4_after_flt", mem_words[4], 32'h1234_BEEF);
    do_req(1'b0, 3'b110, 32'h10, 32'h0, rd);

    // Reset in the middle of a store, before the falling edge of ACCESS.
    do_req(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, rd);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_wen_before", 32'(mem_wen), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_wen_dropped", 32'(mem_wen), 32'd0);
    check("mid_sel_dropped", 32'(mem_byte_selector), 32'd0);
    check("mid_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("mid_no_resp", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_ready_after", 32'(req_ready), 32'd1);
    check("mid_word_kept", mem_words[8], ref_word(8'h20));
    @(posedge clk); #1;
    check("mid_no_resp2", 32'(resp_valid), 32'd0);

    // Back-to-back: req_valid held high for 12 edges.
    n_acc      = 0;
    n_rsp      = 0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("b2b_ready", 32'(req_ready), 32'((i % 3) == 0));
      if (req_ready) n_acc++;
      if (resp_valid) n_rsp++;
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd4);
    check("b2b_resps", 32'(n_rsp), 32'd4);
    @(posedge clk); #1;

    // Random requests against the reference model.
    for (int t = 0; t < 120; t++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) a = a | 32'h0000_4000;
      do_req(we, f3, a, $urandom, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
